ram_sx_arb: RTL and testbench

Round-robin arbiter sharing one single-port fake RAM (RamSX-style: one address, one write/read strobe pair, registered read data) between CReqCnt requesters. Each cycle it grants at most one request, drives the RAM port from the winner and routes the one-cycle-late read data back to the requester that issued the read. It sits between core-side memory clients (fetch, load/store, DMA) and the RAM instance. All state advances only on enabled clock cycles.

---
 rtl/ram_sx_arb_pkg.sv | 10 +
 rtl/ram_sx_arb_rr.sv | 24 ++
 rtl/ram_sx_arb.sv | 74 +++++++
 tb/tb_ram_sx_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sx_arb_pkg.sv
// ram_sx_arb_pkg: requester-count bound and index helpers shared by the RAM arbiter files
package ram_sx_arb_pkg;
   localparam int CReqCntMax = 8;
   function automatic int idxW(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
   function automatic logic [CReqCntMax-1:0] oneHot(input int i);
      return CReqCntMax'(1) << i;
   endfunction
endpackage

// File: rtl/ram_sx_arb_rr.sv
// ram_sx_arb_rr: combinational round-robin picker, first active index after ALast with wrap
module ram_sx_arb_rr
   import ram_sx_arb_pkg::*;
#(
   parameter int CReqCnt = 4,
   parameter int CIdxW = idxW(CReqCnt)
)(
   input  logic [CReqCnt-1:0] AActive,
   input  logic [CIdxW-1:0]   ALast,
   output logic [CIdxW-1:0]   AWin,
   output logic               AWinVld
);
   // Scan farthest-first so the nearest active index after ALast is the last to overwrite
   always_comb begin
      AWin = '0;
      AWinVld = 1'b0;
      for (int k = CReqCnt; k >= 1; k--) begin
         if (AActive[(int'(ALast) + k) % CReqCnt]) begin
            AWin = CIdxW'((int'(ALast) + k) % CReqCnt);
            AWinVld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ram_sx_arb.sv
// ram_sx_arb: round-robin arbiter sharing one single-port registered-read RAM among CReqCnt requesters
// Optional RAM_SX_ARB_LOCK_EN: a requester may hold the grant across accesses for read-modify-write
module ram_sx_arb
   import ram_sx_arb_pkg::*;
#(
   parameter int CAddrLen = 13,
   parameter int CDataLen = 128,
   parameter int CReqCnt = 4
)(
   input  logic                         AClkH,
   input  logic                         AResetH,
   input  logic                         AClkHEn,
   input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
   input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
   input  logic [CReqCnt-1:0]           AReqWrEn,
   input  logic [CReqCnt-1:0]           AReqRdEn,
   input  logic [CReqCnt-1:0]           AReqLock,
   output logic [CReqCnt-1:0]           AReqAck,
   output logic [CDataLen-1:0]          AReqMiso,
   output logic [CReqCnt-1:0]           AReqMisoVld,
   output logic [CAddrLen-1:0]          ARamAddr,
   output logic [CDataLen-1:0]          ARamMosi,
   output logic                         ARamWrEn,
   output logic                         ARamRdEn,
   input  logic [CDataLen-1:0]          ARamMiso
);
   localparam int CIdxW = idxW(CReqCnt);
   logic [CIdxW-1:0] FLast, FRdOwn, win;
   logic FRdPend, winVld, ack, retVld;
   logic [CReqCnt-1:0] active;
`ifdef RAM_SX_ARB_LOCK_EN
   logic FLockVld;
   logic [CIdxW-1:0] FLockOwn;
   assign active = (AReqWrEn | AReqRdEn) & (FLockVld ? CReqCnt'(oneHot(int'(FLockOwn))) : '1);
`else
   logic unusedLock;
   assign unusedLock = ^AReqLock;
   assign active = AReqWrEn | AReqRdEn;
`endif
   ram_sx_arb_rr #(.CReqCnt(CReqCnt), .CIdxW(CIdxW)) uRr (
      .AActive(active),
      .ALast(FLast),
      .AWin(win),
      .AWinVld(winVld)
   );
   assign ack = winVld & AClkHEn & ~AResetH;
   assign AReqAck = ack ? CReqCnt'(oneHot(int'(win))) : '0;
   assign ARamAddr = ack ? AReqAddr[int'(win)*CAddrLen +: CAddrLen] : '0;
   assign ARamMosi = ack ? AReqMosi[int'(win)*CDataLen +: CDataLen] : '0;
   assign ARamWrEn = ack & AReqWrEn[win];
   assign ARamRdEn = ack & AReqRdEn[win];
   assign retVld = FRdPend & ~AResetH;
   assign AReqMisoVld = retVld ? CReqCnt'(oneHot(int'(FRdOwn))) : '0;
   assign AReqMiso = retVld ? ARamMiso : '0;
   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         FLast <= CIdxW'(CReqCnt - 1);
         FRdPend <= 1'b0;
         FRdOwn <= '0;
`ifdef RAM_SX_ARB_LOCK_EN
         FLockVld <= 1'b0;
         FLockOwn <= '0;
`endif
      end else if (AClkHEn) begin
         FRdPend <= ack & AReqRdEn[win];
         if (ack) FLast <= win;
         if (ack & AReqRdEn[win]) FRdOwn <= win;
`ifdef RAM_SX_ARB_LOCK_EN
         if (ack) FLockVld <= AReqLock[win];
         if (ack & AReqLock[win]) FLockOwn <= win;
`endif
      end
   end
endmodule

// File: tb/tb_ram_sx_arb.sv
// tb_ram_sx_arb: scoreboard bench for ram_sx_arb driving a behavioural registered-read RAM
module tb_ram_sx_arb;
   localparam int N = 4;
   localparam int AW = 13;
   localparam int DW = 128;
   logic clk = 1'b0;
   logic rst, en;
   logic [N*AW-1:0] reqAddr;
   logic [N*DW-1:0] reqMosi;
   logic [N-1:0] wr, rd, lk, ack, misoVld;
   logic [DW-1:0] miso, ramMosi;
   logic [DW-1:0] ramMiso = '0;
   logic [AW-1:0] ramAddr;
   logic ramWr, ramRd;
   int checks = 0;
   int errors = 0;
   typedef struct {int own; logic [DW-1:0] data;} ret_t;
   ret_t q[$];
   logic [DW-1:0] expMem [0:(1<<AW)-1];
   logic [DW-1:0] ramMem [0:(1<<AW)-1];
   int lastExp = N - 1;
   bit lockVld = 0;
   int lockOwn = 0;
   localparam logic [DW-1:0] PatA5 = {16{8'hA5}};

   always #5 clk = ~clk;

   ram_sx_arb #(.CAddrLen(AW), .CDataLen(DW), .CReqCnt(N)) dut (
      .AClkH(clk), .AResetH(rst), .AClkHEn(en),
      .AReqAddr(reqAddr), .AReqMosi(reqMosi), .AReqWrEn(wr), .AReqRdEn(rd), .AReqLock(lk),
      .AReqAck(ack), .AReqMiso(miso), .AReqMisoVld(misoVld),
      .ARamAddr(ramAddr), .ARamMosi(ramMosi), .ARamWrEn(ramWr), .ARamRdEn(ramRd),
      .ARamMiso(ramMiso)
   );

   // Single-port RAM with registered read (old data on simultaneous write)
   always @(posedge clk) begin
      if (en) begin
         if (ramRd) ramMiso <= ramMem[ramAddr];
         if (ramWr) ramMem[ramAddr] <= ramMosi;
      end
   end

   function automatic int addrOf(input int i);
      return int'(reqAddr[i*AW +: AW]);
   endfunction

   function automatic logic [N-1:0] expAck();
      logic [N-1:0] act = wr | rd;
      if (lockVld) act = act & (N'(1) << lockOwn);
      if (!en || rst) return '0;
      for (int k = 1; k <= N; k++)
         if (act[(lastExp + k) % N]) return N'(1) << ((lastExp + k) % N);
      return '0;
   endfunction

   function automatic logic [N-1:0] expVld();
      return (q.size() == 0 || rst) ? '0 : N'(1) << q[0].own;
   endfunction

   function automatic logic [DW-1:0] expMiso();
      return (q.size() == 0 || rst) ? '0 : q[0].data;
   endfunction

   // Advance the reference model for the edge that follows the current cycle
   task automatic commit();
      logic [N-1:0] a = expAck();
      int w = -1;
      if (rst) begin
         q.delete();
         lastExp = N - 1;
         lockVld = 0;
         return;
      end
      if (!en) return;
      if (q.size() != 0) void'(q.pop_front());
      for (int i = 0; i < N; i++) if (a[i]) w = i;
      if (w < 0) return;
      lastExp = w;
      if (rd[w]) q.push_back('{own: w, data: expMem[addrOf(w)]});
      if (wr[w]) expMem[addrOf(w)] = reqMosi[w*DW +: DW];
      lockVld = lk[w];
      if (lk[w]) lockOwn = w;
   endtask

   task automatic setReq(input int i, input bit w, input bit r, input int a, input logic [DW-1:0] d, input bit l);
      wr[i] = w;
      rd[i] = r;
      lk[i] = l;
      reqAddr[i*AW +: AW] = AW'(a);
      reqMosi[i*DW +: DW] = d;
   endtask

   task automatic idle();
      wr = '0; rd = '0; lk = '0; reqAddr = '0; reqMosi = '0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1; en = 1; idle();
      commit();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; en = 1; idle();
      setReq(1, 0, 1, 7, '0, 0);
      #1;
      checks++;
      if (ack !== '0 || ramRd !== 1'b0) begin errors++; $display("FAIL reset_hold: ack %b rd %b want 0", ack, ramRd); end
      commit();
      @(negedge clk);
      rst = 0; idle();
      #1;
      checks++;
      if (ack !== '0 || misoVld !== '0) begin errors++; $display("FAIL reset_ack: ack %b vld %b want 0", ack, misoVld); end
      checks++;
      if (ramWr !== 1'b0 || ramRd !== 1'b0 || ramAddr !== '0 || ramMosi !== '0 || miso !== '0)
         begin errors++; $display("FAIL reset_ram: wr %b rd %b addr %h mosi %h miso %h want 0", ramWr, ramRd, ramAddr, ramMosi, miso); end
      commit();
   endtask

   task automatic test_single();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle();
         if (c == 0) setReq(2, 1, 0, 5, PatA5, 0);
         if (c == 1) setReq(2, 0, 1, 5, '0, 0);
         #1;
         checks++;
         if (ack !== expAck() || ack !== (c < 2 ? 4'b0100 : 4'b0000))
            begin errors++; $display("FAIL single_ack c%0d: got %b want %b", c, ack, expAck()); end
         checks++;
         if (misoVld !== expVld() || miso !== expMiso())
            begin errors++; $display("FAIL single_ret c%0d: vld %b data %h want %b %h", c, misoVld, miso, expVld(), expMiso()); end
         if (c == 0) begin
            checks++;
            if (ramWr !== 1'b1 || ramRd !== 1'b0 || ramAddr !== 13'd5 || ramMosi !== PatA5)
               begin errors++; $display("FAIL single_wr: wr %b rd %b addr %h mosi %h", ramWr, ramRd, ramAddr, ramMosi); end
         end
         if (c == 2) begin
            checks++;
            if (misoVld !== 4'b0100 || miso !== PatA5)
               begin errors++; $display("FAIL single_rd: vld %b data %h want 0100 %h", misoVld, miso, PatA5); end
         end
         commit();
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      idle();
      for (int i = 0; i < N; i++) setReq(i, 0, 0, 100 + i, {4{32'hDEAD0000 + i}}, 0);
      #1;
      checks++;
      if (ack !== '0 || ramWr !== 1'b0 || ramRd !== 1'b0 || ramAddr !== '0 || ramMosi !== '0 || miso !== '0 || misoVld !== '0)
         begin errors++; $display("FAIL idle: ack %b wr %b rd %b addr %h mosi %h miso %h", ack, ramWr, ramRd, ramAddr, ramMosi, miso); end
      commit();
   endtask

   task automatic test_round_robin();
      doReset();
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         idle();
         if (c < 8) for (int i = 0; i < N; i++) setReq(i, 0, 1, (i == 2) ? 5 : 9, '0, 0);
         #1;
         checks++;
         if (ack !== expAck() || ack !== (c < 8 ? N'(1) << (c % N) : N'(0)))
            begin errors++; $display("FAIL rr_ack c%0d: got %b want %b", c, ack, expAck()); end
         checks++;
         if (misoVld !== expVld() || miso !== expMiso() || misoVld !== (c > 0 ? N'(1) << ((c - 1) % N) : N'(0)))
            begin errors++; $display("FAIL rr_ret c%0d: vld %b data %h want %b %h", c, misoVld, miso, expVld(), expMiso()); end
         commit();
      end
   endtask

   task automatic test_enable();
      doReset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         idle();
         en = (c == 0 || c >= 4);
         if (c == 0) setReq(1, 0, 1, 5, '0, 0);
         if (c >= 1 && c <= 4) for (int i = 0; i < N; i++) setReq(i, 0, i != 1 || c == 4, 5, '0, 0);
         #1;
         checks++;
         if (ack !== expAck()) begin errors++; $display("FAIL en_ack c%0d: got %b want %b", c, ack, expAck()); end
         checks++;
         if (misoVld !== expVld() || miso !== expMiso())
            begin errors++; $display("FAIL en_ret c%0d: vld %b data %h want %b %h", c, misoVld, miso, expVld(), expMiso()); end
         if (c >= 1 && c <= 3) begin
            checks++;
            if (ack !== '0 || misoVld !== 4'b0010 || miso !== PatA5)
               begin errors++; $display("FAIL en_hold c%0d: ack %b vld %b data %h want 0000 0010 %h", c, ack, misoVld, miso, PatA5); end
         end
         if (c == 4) begin
            checks++;
            if (ack !== 4'b0100) begin errors++; $display("FAIL en_last: ack %b want 0100", ack); end
         end
         commit();
      end
   endtask

   task automatic test_reset_mid_read();
      doReset();
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         idle();
         rst = (c == 1);
         if (c == 0) setReq(3, 0, 1, 5, '0, 0);
         if (c == 1 || c == 2) for (int i = 0; i < N; i++) setReq(i, 0, 1, 5, '0, 0);
         #1;
         checks++;
         if (ack !== expAck() || ack !== (c == 0 ? 4'b1000 : c == 2 ? 4'b0001 : 4'b0000))
            begin errors++; $display("FAIL rst_ack c%0d: got %b want %b", c, ack, expAck()); end
         checks++;
         if (misoVld !== expVld() || miso !== expMiso() || misoVld !== (c == 3 ? 4'b0001 : 4'b0000))
            begin errors++; $display("FAIL rst_ret c%0d: vld %b data %h want %b %h", c, misoVld, miso, expVld(), expMiso()); end
         commit();
      end
   endtask

`ifdef RAM_SX_ARB_LOCK_EN
   task automatic test_lock();
      logic [N-1:0] want [0:5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
      doReset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         idle();
         if (c == 0) setReq(1, 0, 1, 5, '0, 1);
         if (c >= 1 && c <= 4) for (int i = 0; i < N; i++) if (i != 1) setReq(i, 0, 1, 5, '0, 0);
         if (c == 3) setReq(1, 1, 0, 5, {16{8'h3C}}, 0);
         #1;
         checks++;
         if (ack !== expAck() || ack !== want[c])
            begin errors++; $display("FAIL lock_ack c%0d: got %b want %b", c, ack, want[c]); end
         checks++;
         if (misoVld !== expVld() || miso !== expMiso())
            begin errors++; $display("FAIL lock_ret c%0d: vld %b data %h want %b %h", c, misoVld, miso, expVld(), expMiso()); end
         commit();
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ramMem[i] = '0;
         expMem[i] = '0;
      end
      rst = 1; en = 1; idle();
      test_reset();
      test_single();
      test_idle();
      test_round_robin();
      test_enable();
      test_reset_mid_read();
`ifdef RAM_SX_ARB_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
